// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, blanking, active-low syncs
// with frame-latched signed offsets, a PIPE-deep alignment delay for a slow
// game core, registered RGB, and line/frame strobes with a field bit.
module video_timing_gen #(
   parameter int H_TOTAL      = 456,
   parameter int H_ACTIVE     = 336,
   parameter int H_SYNC_START = 360,
   parameter int H_SYNC_WIDTH = 24,
   parameter int V_TOTAL      = 262,
   parameter int V_ACTIVE     = 240,
   parameter int V_SYNC_START = 240,
   parameter int V_SYNC_WIDTH = 3,
   parameter int RGB_W        = 8,
   parameter int PIPE         = 1
) (
   input  logic             MCLK,
   input  logic             RESET_N,
   input  logic             CE,
   input  logic [4:0]       HOFFS,
   input  logic [3:0]       VOFFS,
   input  logic [RGB_W-1:0] iRGB,
   output logic [8:0]       HPOS,
   output logic [8:0]       VPOS,
   output logic [RGB_W-1:0] oRGB,
   output logic             HBLK,
   output logic             VBLK,
   output logic             HSYN,
   output logic             VSYN,
   output logic             LINE_STB,
   output logic             FRAME_STB,
   output logic             FIELD
);

   localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
   localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
   localparam logic [8:0] H_ACT9 = 9'(H_ACTIVE);
   localparam logic [8:0] V_ACT9 = 9'(V_ACTIVE);
   localparam logic signed [10:0] HS_NOM = 11'(H_SYNC_START);
   localparam logic signed [10:0] HS_MIN = 11'(H_ACTIVE);
   localparam logic signed [10:0] HS_MAX = 11'(H_TOTAL - H_SYNC_WIDTH);
   localparam logic signed [10:0] VS_NOM = 11'(V_SYNC_START);
   localparam logic signed [10:0] VS_MIN = 11'(V_ACTIVE);
   localparam logic signed [10:0] VS_MAX = 11'(V_TOTAL - V_SYNC_WIDTH);
   localparam logic [9:0] HS_W10 = 10'(H_SYNC_WIDTH);
   localparam logic [9:0] VS_W10 = 10'(V_SYNC_WIDTH);
   // Delay-line reset image {hb, vb, hs, vs}: blanked, no sync.
   localparam logic [3:0] DLY_RST = 4'b1100;

   logic [8:0]       hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic [4:0]       hoffs_q, hoffs_d;
   logic [3:0]       voffs_q, voffs_d;
   logic             field_q, field_d;
   logic             hblk_q, hblk_d, vblk_q, vblk_d;
   logic             hsyn_q, hsyn_d, vsyn_q, vsyn_d;
   logic [RGB_W-1:0] orgb_q, orgb_d;
   logic             h_wrap, f_wrap;
   logic signed [10:0] hs_off, vs_off, hs_raw, vs_raw;
   logic [8:0]       hs_b, vs_b;
   logic [3:0]       raw_tim, tim_dly;

   // Counter advance, offset capture on the (0,0) wrap, field toggle.
   always_comb begin
      h_wrap  = (hcnt_q == H_LAST);
      f_wrap  = h_wrap && (vcnt_q == V_LAST);
      hcnt_d  = hcnt_q;
      vcnt_d  = vcnt_q;
      hoffs_d = hoffs_q;
      voffs_d = voffs_q;
      field_d = field_q;
      if (CE) begin
         hcnt_d = h_wrap ? 9'd0 : hcnt_q + 9'd1;
         if (h_wrap) vcnt_d = f_wrap ? 9'd0 : vcnt_q + 9'd1;
         if (f_wrap) begin
            hoffs_d = HOFFS;
            voffs_d = VOFFS;
            field_d = ~field_q;
         end
      end
   end

   // Effective sync starts (offset step of 2, clamped so the window never
   // crosses the end of the line/frame) and raw timing for this position.
   always_comb begin
      hs_off = {{5{hoffs_q[4]}}, hoffs_q, 1'b0};
      vs_off = {{6{voffs_q[3]}}, voffs_q, 1'b0};
      hs_raw = HS_NOM + hs_off;
      vs_raw = VS_NOM + vs_off;
      if (hs_raw < HS_MIN)      hs_b = HS_MIN[8:0];
      else if (hs_raw > HS_MAX) hs_b = HS_MAX[8:0];
      else                      hs_b = hs_raw[8:0];
      if (vs_raw < VS_MIN)      vs_b = VS_MIN[8:0];
      else if (vs_raw > VS_MAX) vs_b = VS_MAX[8:0];
      else                      vs_b = vs_raw[8:0];
      raw_tim[3] = (hcnt_q >= H_ACT9);
      raw_tim[2] = (vcnt_q >= V_ACT9);
      raw_tim[1] = ({1'b0, hcnt_q} >= {1'b0, hs_b}) &&
                   ({1'b0, hcnt_q} <  ({1'b0, hs_b} + HS_W10));
      raw_tim[0] = ({1'b0, vcnt_q} >= {1'b0, vs_b}) &&
                   ({1'b0, vcnt_q} <  ({1'b0, vs_b} + VS_W10));
   end

   generate
      if (PIPE == 0) begin : g_bypass
         assign tim_dly = raw_tim;
      end else begin : g_dly
         logic [3:0] dly_q [PIPE];
         logic [3:0] dly_d [PIPE];

         // Shift raw timing one stage per CE tick to match core latency.
         always_comb begin
            dly_d = dly_q;
            if (CE) begin
               dly_d[0] = raw_tim;
               for (int i = 1; i < PIPE; i++) dly_d[i] = dly_q[i-1];
            end
         end

         // Delay-line storage, reset to the blanked image.
         always_ff @(posedge MCLK or negedge RESET_N) begin
            if (!RESET_N) begin
               for (int i = 0; i < PIPE; i++) dly_q[i] <= DLY_RST;
            end else begin
               dly_q <= dly_d;
            end
         end

         assign tim_dly = dly_q[PIPE-1];
      end
   endgenerate

   // Output register: delayed timing, syncs inverted, RGB blanked.
   always_comb begin
      hblk_d = hblk_q;
      vblk_d = vblk_q;
      hsyn_d = hsyn_q;
      vsyn_d = vsyn_q;
      orgb_d = orgb_q;
      if (CE) begin
         hblk_d = tim_dly[3];
         vblk_d = tim_dly[2];
         hsyn_d = ~tim_dly[1];
         vsyn_d = ~tim_dly[0];
         orgb_d = (tim_dly[3] | tim_dly[2]) ? '0 : iRGB;
      end
   end

   // State registers for counters, latched offsets, field and outputs.
   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hcnt_q  <= '0;
         vcnt_q  <= '0;
         hoffs_q <= '0;
         voffs_q <= '0;
         field_q <= 1'b0;
         hblk_q  <= 1'b1;
         vblk_q  <= 1'b1;
         hsyn_q  <= 1'b1;
         vsyn_q  <= 1'b1;
         orgb_q  <= '0;
      end else begin
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         hoffs_q <= hoffs_d;
         voffs_q <= voffs_d;
         field_q <= field_d;
         hblk_q  <= hblk_d;
         vblk_q  <= vblk_d;
         hsyn_q  <= hsyn_d;
         vsyn_q  <= vsyn_d;
         orgb_q  <= orgb_d;
      end
   end

   // Strobes mark the CE cycle that performs the wrap, so they are
   // combinational and cannot outlast a single MCLK.
   assign LINE_STB  = CE & h_wrap;
   assign FRAME_STB = CE & f_wrap;
   assign HPOS      = hcnt_q;
   assign VPOS      = vcnt_q;
   assign oRGB      = orgb_q;
   assign HBLK      = hblk_q;
   assign VBLK      = vblk_q;
   assign HSYN      = hsyn_q;
   assign VSYN      = vsyn_q;
   assign FIELD     = field_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (PIPE 0, 1, 3) on a small
// geometry, checked every cycle against a position/frame arithmetic model.
module tb_video_timing_gen;

   localparam int HT = 40, HA = 24, HSS = 28, HSW = 4;
   localparam int VT = 20, VA = 14, VSS = 15, VSW = 2;
   localparam int FT = HT * VT;

   logic mclk = 1'b0;
   logic rst_n = 1'b0;
   logic ce = 1'b0;
   logic [4:0] hoffs = '0;
   logic [3:0] voffs = '0;
   logic [7:0] irgb_0, irgb_1, irgb_3;
   logic [8:0] hpos_0, vpos_0, hpos_1, vpos_1, hpos_3, vpos_3;
   logic [7:0] orgb_0, orgb_1, orgb_3;
   logic hblk_0, vblk_0, hsyn_0, vsyn_0, lstb_0, fstb_0, field_0;
   logic hblk_1, vblk_1, hsyn_1, vsyn_1, lstb_1, fstb_1, field_1;
   logic hblk_3, vblk_3, hsyn_3, vsyn_3, lstb_3, fstb_3, field_3;

   int total = 0;
   int bad = 0;
   int n = 0;                 // CE ticks since reset release
   int hoff_f [64];           // offsets in force for each frame
   int voff_f [64];
   int hs_meas = -1, vs_meas = -1;
   logic prev_hs1 = 1'b1, prev_vs1 = 1'b1;

   always #5 mclk = ~mclk;

   video_timing_gen #(.H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
      .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW), .RGB_W(8), .PIPE(0))
   u_dut0 (.MCLK(mclk), .RESET_N(rst_n), .CE(ce), .HOFFS(hoffs), .VOFFS(voffs), .iRGB(irgb_0),
      .HPOS(hpos_0), .VPOS(vpos_0), .oRGB(orgb_0), .HBLK(hblk_0), .VBLK(vblk_0), .HSYN(hsyn_0),
      .VSYN(vsyn_0), .LINE_STB(lstb_0), .FRAME_STB(fstb_0), .FIELD(field_0));

   video_timing_gen #(.H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
      .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW), .RGB_W(8), .PIPE(1))
   u_dut1 (.MCLK(mclk), .RESET_N(rst_n), .CE(ce), .HOFFS(hoffs), .VOFFS(voffs), .iRGB(irgb_1),
      .HPOS(hpos_1), .VPOS(vpos_1), .oRGB(orgb_1), .HBLK(hblk_1), .VBLK(vblk_1), .HSYN(hsyn_1),
      .VSYN(vsyn_1), .LINE_STB(lstb_1), .FRAME_STB(fstb_1), .FIELD(field_1));

   video_timing_gen #(.H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
      .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW), .RGB_W(8), .PIPE(3))
   u_dut3 (.MCLK(mclk), .RESET_N(rst_n), .CE(ce), .HOFFS(hoffs), .VOFFS(voffs), .iRGB(irgb_3),
      .HPOS(hpos_3), .VPOS(vpos_3), .oRGB(orgb_3), .HBLK(hblk_3), .VBLK(vblk_3), .HSYN(hsyn_3),
      .VSYN(vsyn_3), .LINE_STB(lstb_3), .FRAME_STB(fstb_3), .FIELD(field_3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d tick=%0d", tag, obs, expv, n);
      end
   endtask

   function automatic int clampi(input int x, input int lo, input int hi);
      return (x < lo) ? lo : ((x > hi) ? hi : x);
   endfunction

   // Pixel content the core returns for tick index m (position-dependent).
   function automatic logic [7:0] pix(input int m);
      return 8'((m % HT) + 7 * ((m / HT) % VT) + 13 * (m / FT));
   endfunction

   function automatic logic [7:0] rgb_for(input int idx, input int p);
      if (idx - p < 0) return 8'($urandom_range(0, 255));
      return pix(idx - p);
   endfunction

   task automatic check_dut(input int p, input logic [8:0] hp, input logic [8:0] vp,
                            input logic [7:0] rgb, input logic hb, input logic vb,
                            input logic hs, input logic vs, input logic fld);
      int m, f, h, v, hsb, vsb;
      logic ehb, evb, ehs, evs;
      logic [7:0] ergb;
      chk($sformatf("p%0d_hpos", p), hp, n % HT);
      chk($sformatf("p%0d_vpos", p), vp, (n / HT) % VT);
      chk($sformatf("p%0d_field", p), fld, (n / FT) % 2);
      m = n - 1 - p;
      if (m < 0) begin
         ehb = 1'b1; evb = 1'b1; ehs = 1'b1; evs = 1'b1; ergb = 8'd0;
      end else begin
         f = m / FT; h = m % HT; v = (m / HT) % VT;
         hsb = clampi(HSS + 2 * hoff_f[f], HA, HT - HSW);
         vsb = clampi(VSS + 2 * voff_f[f], VA, VT - VSW);
         ehb = (h >= HA);
         evb = (v >= VA);
         ehs = !(h >= hsb && h < hsb + HSW);
         evs = !(v >= vsb && v < vsb + VSW);
         ergb = (ehb || evb) ? 8'd0 : pix(m);
      end
      chk($sformatf("p%0d_hblk", p), hb, ehb);
      chk($sformatf("p%0d_vblk", p), vb, evb);
      chk($sformatf("p%0d_hsyn", p), hs, ehs);
      chk($sformatf("p%0d_vsyn", p), vs, evs);
      chk($sformatf("p%0d_orgb", p), rgb, ergb);
   endtask

   task automatic check_all();
      check_dut(0, hpos_0, vpos_0, orgb_0, hblk_0, vblk_0, hsyn_0, vsyn_0, field_0);
      check_dut(1, hpos_1, vpos_1, orgb_1, hblk_1, vblk_1, hsyn_1, vsyn_1, field_1);
      check_dut(3, hpos_3, vpos_3, orgb_3, hblk_3, vblk_3, hsyn_3, vsyn_3, field_3);
   endtask

   task automatic check_strobes(input bit c);
      logic els, efs;
      els = c && (n % HT == HT - 1);
      efs = c && (n % FT == FT - 1);
      chk("p0_line_stb", lstb_0, els);  chk("p0_frame_stb", fstb_0, efs);
      chk("p1_line_stb", lstb_1, els);  chk("p1_frame_stb", fstb_1, efs);
      chk("p3_line_stb", lstb_3, els);  chk("p3_frame_stb", fstb_3, efs);
   endtask

   // One MCLK cycle; entered and left at posedge+1.
   task automatic step(input bit c);
      int m;
      ce = c;
      irgb_0 = rgb_for(n, 0);
      irgb_1 = rgb_for(n, 1);
      irgb_3 = rgb_for(n, 3);
      @(negedge mclk);
      check_strobes(c);
      if (c && (n % FT == FT - 1)) begin
         hoff_f[n / FT + 1] = int'($signed(hoffs));
         voff_f[n / FT + 1] = int'($signed(voffs));
      end
      @(posedge mclk);
      #1;
      if (c) n++;
      check_all();
      m = n - 2;
      if (prev_hs1 && !hsyn_1 && m >= 0) hs_meas = m % HT;
      if (prev_vs1 && !vsyn_1 && m >= 0) vs_meas = (m / HT) % VT;
      prev_hs1 = hsyn_1;
      prev_vs1 = vsyn_1;
   endtask

   task automatic run_until(input int target);
      while (n < target) step(1'b1);
   endtask

   // mode 0: CE=1; mode 1: CE 1-in-4 + random offsets; mode 2: random CE + offsets
   task automatic run_to_frame_end(input int mode);
      int start, cyc;
      bit c;
      start = n / FT;
      cyc = 0;
      while (n / FT == start && cyc < 20000) begin
         c = 1'b1;
         if (mode != 0) begin
            hoffs = 5'($urandom);
            voffs = 4'($urandom);
            c = (mode == 1) ? (cyc % 4 == 0) : bit'($urandom_range(0, 1));
         end
         step(c);
         cyc++;
      end
      chk("frame_end_reached", 32'(n / FT), 32'(start + 1));
   endtask

   task automatic reset_model();
      n = 0;
      hoff_f[0] = 0;
      voff_f[0] = 0;
      prev_hs1 = 1'b1;
      prev_vs1 = 1'b1;
   endtask

   initial begin
      reset_model();
      @(posedge mclk);
      #1;
      check_all();
      check_strobes(1'b0);
      rst_n = 1'b1;

      // Nominal geometry, offsets 0.
      run_to_frame_end(0);
      chk("hs_start_nominal", hs_meas, 28);
      chk("vs_line_nominal", vs_meas, 15);

      // Offsets changed mid-frame: only the next frame sees them.
      run_until(FT + 5 * HT);
      hoffs = 5'd3;
      voffs = 4'd7;
      run_to_frame_end(0);
      chk("hs_start_same_frame", hs_meas, 28);
      chk("vs_line_same_frame", vs_meas, 15);
      run_to_frame_end(0);
      chk("hs_start_plus3", hs_meas, 34);
      chk("vs_line_clamp_hi", vs_meas, 18);

      // Most negative offsets clamp to the start of blanking.
      run_until(n + 3 * HT + 7);
      hoffs = 5'b10000;
      voffs = 4'b1000;
      run_to_frame_end(0);
      chk("hs_start_held", hs_meas, 34);
      run_to_frame_end(0);
      chk("hs_start_clamp_lo", hs_meas, 24);
      chk("vs_line_clamp_lo", vs_meas, 14);

      // Offset changed on the very wrap cycle is captured.
      run_until(n + FT - 1);
      hoffs = 5'd15;
      voffs = 4'd0;
      step(1'b1);
      run_to_frame_end(0);
      chk("hs_start_clamp_hi", hs_meas, 36);
      chk("vs_line_wrap_capture", vs_meas, 15);

      // Sparse and random CE with offsets churning every cycle.
      run_to_frame_end(1);
      run_to_frame_end(2);
      run_to_frame_end(2);

      // Asynchronous reset mid-line while CE is high.
      hoffs = 5'd0;
      voffs = 4'd0;
      run_until(n + 10);
      ce = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      reset_model();
      check_all();
      check_strobes(1'b1);
      @(posedge mclk);
      #1;
      check_all();
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) step(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator, the successor to the fixed 336x240 arcade timing block. It produces pixel and line counters, blanking and active-low sync signals, and registered RGB output for any H/V geometry. Three things are new: signed sync offsets that are clamped and latched only at frame boundaries, a configurable pixel-pipeline delay that aligns timing outputs with a slow game core, and line/frame strobes with a field bit. It sits between the game core (which consumes HPOS/VPOS and returns iRGB) and the arcade video/scaler path.

## Interface
Parameters:
- H_TOTAL, 456: pixels per line, including blanking.
- H_ACTIVE, 336: visible pixels per line.
- H_SYNC_START, 360: nominal HSYN start pixel.
- H_SYNC_WIDTH, 24: HSYN low width, in pixels.
- V_TOTAL, 262: lines per frame.
- V_ACTIVE, 240: visible lines.
- V_SYNC_START, 240: nominal VSYN start line.
- V_SYNC_WIDTH, 3: VSYN low width, in lines.
- RGB_W, 8: pixel data width.
- PIPE, 1: game-core pixel latency in CE ticks. Legal range 0..4.

Ports:
- MCLK  in  1  sole clock.
- RESET_N  in  1  asynchronous, active-low reset.
- CE  in  1  pixel clock enable. All state advances only when CE=1.
- HOFFS  in  5  signed (two's complement) horizontal sync offset. Step is 2 pixels.
- VOFFS  in  4  signed vertical sync offset. Step is 2 lines.
- iRGB  in  RGB_W  pixel from the core for the position presented PIPE ticks earlier.
- HPOS  out  9  current pixel counter.
- VPOS  out  9  current line counter.
- oRGB  out  RGB_W  registered pixel. Forced to 0 during blanking.
- HBLK, VBLK  out  1  blanking, active high.
- HSYN, VSYN  out  1  sync, active low.
- LINE_STB  out  1  one-MCLK pulse on the CE tick where hcnt wraps to 0.
- FRAME_STB  out  1  one-MCLK pulse on the CE tick where hcnt and vcnt both wrap to 0.
- FIELD  out  1  toggles at every frame wrap.

## Operation
- Counters:
  - hcnt runs 0..H_TOTAL-1, then wraps to 0.
  - vcnt increments on each hcnt wrap and runs 0..V_TOTAL-1.
  - HPOS=hcnt and VPOS=vcnt, driven combinationally from the counter registers.
- Offset latch:
  - HOFFS and VOFFS are captured into internal registers only on the CE tick that wraps to (0,0).
  - Changes on these inputs mid-frame have no effect until the next frame.
- Effective sync start:
  - hs_b = H_SYNC_START + 2*HOFFS, computed signed at 11 bits.
  - hs_b is clamped to [H_ACTIVE, H_TOTAL-H_SYNC_WIDTH].
  - vs_b is computed and clamped the same way over [V_ACTIVE, V_TOTAL-V_SYNC_WIDTH].
- Raw timing per position:
  - hb = (hcnt >= H_ACTIVE)
  - vb = (vcnt >= V_ACTIVE)
  - hs = hcnt in [hs_b, hs_b+H_SYNC_WIDTH)
  - vs = vcnt in [vs_b, vs_b+V_SYNC_WIDTH)
- Delay line: {hb, vb, hs, vs} pass through a PIPE-deep shift register that advances on CE. When PIPE=0 the line is bypassed.
- Output register, updated on CE:
  - HBLK and VBLK take the delayed hb and vb.
  - HSYN=~hs_d and VSYN=~vs_d.
  - oRGB = (hb_d|vb_d) ? 0 : iRGB.
- Strobes: LINE_STB and FRAME_STB are asserted for exactly one MCLK, on the CE=1 cycle that performs the wrap. They are not delayed by PIPE. FIELD toggles with FRAME_STB.
- Reset values:
  - hcnt = vcnt = 0.
  - HBLK = VBLK = 1.
  - HSYN = VSYN = 1.
  - oRGB = 0.
  - LINE_STB = FRAME_STB = 0, FIELD = 0.
  - Latched offsets = 0.
  - Delay line filled with hb=vb=1, hs=vs=0.

## Timing
- Output latency: timing outputs for position (h,v) appear PIPE+1 CE ticks after HPOS/VPOS presented (h,v). oRGB has the same latency.
- CE=0: every register holds and strobes are 0. CE may be any duty cycle, including constant 1.
- Frame length: exactly H_TOTAL*V_TOTAL CE ticks.
- HSYN: low exactly H_SYNC_WIDTH ticks per line.
- VSYN: low exactly V_SYNC_WIDTH*H_TOTAL ticks per frame, aligned to line start.
- Offset latch vs. wrap: if an offset changes on the same cycle as the frame wrap, the new value is captured.
- Reset: RESET_N low mid-frame takes effect immediately and asynchronously. The first CE after release presents HPOS=0, VPOS=0.
- Arithmetic: sync comparisons use the clamped 9-bit values. The clamp range guarantees the sync window never wraps past H_TOTAL or V_TOTAL.

## Test plan
- Reset: assert RESET_N=0 mid-line with CE=1 -> the reset values listed above appear within the same cycle, with no clock edge needed. After release, HPOS and VPOS step 0,1,2...
- Default geometry, PIPE=1, CE=1, offsets 0 -> per line HBLK low 336 ticks and high 120; HSYN low at delayed pixels 360..383. VBLK high for lines 240..261. LINE_STB occurs every 456 ticks and FRAME_STB every 119472.
- Offset latch: set HOFFS=+3 at line 100 -> the current frame keeps HSYN starting at 360. The next frame starts HSYN at 366, and FIELD toggles once.
- Clamp: HOFFS=-16 -> HSYN start at 336, not 328. HOFFS=+15 -> HSYN start at 390 (below the 432 limit). VOFFS=+7 -> VSYN lines 254..256.
- PIPE=3, with iRGB driven to HPOS[7:0] delayed 3 ticks -> oRGB equals the pixel index on every active pixel, is 0 at HBLK rising and falling edges, and no pixel is misaligned.
- CE at 1-in-4 duty -> counts and widths are identical in CE ticks. Strobes are 1 MCLK wide, and outputs are stable during CE=0 cycles.
